fir_coef_loader: RTL and testbench
==================================

Name: fir_coef_loader

Overview:
Writer side of the FIR coefficient interface. It accepts a stream of FIR_tap coefficients over a valid/ready handshake and stores them in a shadow bank. After a complete, well-formed load it swaps the shadow bank in as the active bank in a single cycle. The filter reads the active bank through the coefficient_addr_in / coefficient_out port, so a filter running mid-load never sees a partially loaded set.

Parameters:
FIR_tap, 16, number of coefficients per set (bank depth)
COEF_W, 16, coefficient width in bits
ADDR_W, 4, index width; must satisfy 2**ADDR_W >= FIR_tap

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
load_start  in  1  pulse: begin a new coefficient load
load_abort  in  1  abandon the load in progress; no swap, no error
coef_valid  in  1  coef_data/coef_last valid
coef_ready  out  1  loader can accept a beat
coef_data  in  COEF_W  coefficient; beat k is written to b[k]
coef_last  in  1  marks the final beat of a set
load_busy  out  1  high while in LOAD
load_done  out  1  one-cycle pulse on a successful swap
load_err  out  1  one-cycle pulse on a malformed load
active_bank  out  1  index of the bank currently served to the filter
coefficient_addr_in  in  16  filter read address
coefficient_out  out  COEF_W  registered read data

Behaviour:
- Synchronous active-high reset, priority over everything, including mid-load.
- Reset values:
  - coef_ready=0, load_busy=0, load_done=0, load_err=0, coefficient_out=0, active_bank=0.
  - Bank0[i]=i+1 (default ramp 1..FIR_tap); bank1 all 0; beat index=0; state=IDLE.
- Accepted beat = coef_valid && coef_ready on a rising edge.
- FSM states: IDLE, LOAD, COMMIT, ERR.
- IDLE:
  - coef_ready=0, load_busy=0.
  - load_start=1 -> LOAD, index cleared to 0.
- LOAD:
  - coef_ready=1 and load_busy=1, both registered, so first high the cycle after load_start.
  - Each accepted beat writes bank[!active_bank][index] and increments index.
  - coef_valid gaps are allowed and hold state.
  - Accepted beat at index==FIR_tap-1 with coef_last=1 -> COMMIT.
  - Accepted beat at index==FIR_tap-1 with coef_last=0 -> ERR (too long / missing last).
  - Accepted beat at index<FIR_tap-1 with coef_last=1 -> ERR (too short).
  - load_abort=1 -> IDLE; takes priority over a same-cycle beat, which is discarded.
  - load_start while in LOAD is ignored.
- COMMIT (1 cycle):
  - coef_ready=0.
  - active_bank toggles on the exit edge.
  - load_done=1 for exactly this one cycle.
  - -> IDLE.
- ERR (1 cycle):
  - coef_ready=0, load_err=1.
  - active_bank unchanged; shadow contents undefined.
  - -> IDLE.
- Shadow writes never touch the active bank.
- Read port:
  - coefficient_out <= active[coefficient_addr_in[ADDR_W-1:0]] when coefficient_addr_in < FIR_tap, else 0.
  - Latency 1 cycle, continuous, independent of FSM state.
  - The read launched on the same edge as the swap returns old-bank data. The next edge returns new-bank data.
- No arithmetic; the width of coef_data equals the storage width (no truncation).
- Back-to-back loads: load_start is accepted in IDLE on the cycle after COMMIT/ERR.

Test Plan:
1. Reset, then read addresses 0..15 -> coefficient_out = 1..16 one cycle after each address; address 16 and 0xFFFF -> 0; active_bank=0.
2. load_start, then 16 beats 100..115 with coef_last on the 16th -> one load_done pulse, active_bank=1, reads return 100..115. Reads issued during the load return 1..16.
3. Same load with coef_valid toggled every other cycle and load_abort=0 -> identical result to scenario 2; index only advances on accepted beats.
4. coef_last on beat 5 -> one load_err pulse, load_done=0, active_bank unchanged, reads still 1..16. Then 16 beats without coef_last -> load_err again, bank unchanged.
5. load_abort after 8 beats, then a fresh full load of 200..215 -> no err, no done on the abort; the second load swaps and all 16 reads are 200..215.
6. rst asserted mid-load after 10 beats -> all outputs at reset values next cycle, active_bank=0, reads return 1..16.

Source files
------------

// File: rtl/fir_coef_loader.sv
// FIR coefficient writer: streams FIR_tap coefficients into a shadow bank and
// swaps it in as the active bank after a complete, well-formed load.
module fir_coef_loader #(
  parameter int unsigned FIR_tap = 16,
  parameter int unsigned COEF_W  = 16,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_last,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic              active_bank,
  input  logic [15:0]       coefficient_addr_in,
  output logic [COEF_W-1:0] coefficient_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                coef_ready_q, coef_ready_d;
  logic                load_busy_q, load_busy_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic                active_bank_q, active_bank_d;
  logic [COEF_W-1:0]   coef_out_q, coef_out_d;
  logic [COEF_W-1:0]   bank_q [2][FIR_tap];
  logic [COEF_W-1:0]   bank_d [2][FIR_tap];
  logic                beat;
  logic                last_idx;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    active_bank_d = active_bank_q;
    bank_d        = bank_q;
    beat          = coef_valid && coef_ready_q;
    last_idx      = (idx_q == ADDR_W'(FIR_tap - 1));

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        // Abort wins over a beat presented on the same edge.
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (beat) begin
          bank_d[~active_bank_q][idx_q] = coef_data;
          idx_d = idx_q + 1'b1;
          if (last_idx) begin
            state_d = coef_last ? S_COMMIT : S_ERR;
          end else if (coef_last) begin
            state_d = S_ERR;
          end
        end
      end
      S_COMMIT: begin
        active_bank_d = ~active_bank_q;
        state_d       = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    coef_ready_d = (state_d == S_LOAD);
    load_busy_d  = (state_d == S_LOAD);
    load_done_d  = (state_d == S_COMMIT);
    load_err_d   = (state_d == S_ERR);

    // Read uses the pre-swap bank select, so the swap edge still returns old data.
    coef_out_d = '0;
    if (32'(coefficient_addr_in) < FIR_tap) begin
      coef_out_d = bank_q[active_bank_q][coefficient_addr_in[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      coef_ready_q  <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      active_bank_q <= 1'b0;
      coef_out_q    <= '0;
      for (int unsigned i = 0; i < FIR_tap; i++) begin
        bank_q[0][i] <= COEF_W'(i + 1);
        bank_q[1][i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      coef_ready_q  <= coef_ready_d;
      load_busy_q   <= load_busy_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
      active_bank_q <= active_bank_d;
      coef_out_q    <= coef_out_d;
      bank_q        <= bank_d;
    end
  end

  assign coef_ready      = coef_ready_q;
  assign load_busy       = load_busy_q;
  assign load_done       = load_done_q;
  assign load_err        = load_err_q;
  assign active_bank     = active_bank_q;
  assign coefficient_out = coef_out_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized bench for fir_coef_loader: transaction-level reference model,
// per-cycle compare process, and literal read-back sweeps.
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_abort = 1'b0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [15:0] coef_data = '0;
  logic        coef_last = 1'b0;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        active_bank;
  logic [15:0] addr = '0;
  logic [15:0] coefficient_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit rand_addr = 1'b0;

  fir_coef_loader #(.FIR_tap(16), .COEF_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_last(coef_last), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .active_bank(active_bank),
    .coefficient_addr_in(addr), .coefficient_out(coefficient_out)
  );

  always #5 clk = ~clk;

  // Reference model: two banks as plain arrays, a loading flag with a beat
  // count, and one-cycle done/err outcomes that gate the next start.
  logic [15:0] m_bank [2][16];
  bit          m_active, m_loading, m_done, m_err, m_valid = 1'b0;
  int          m_cnt;
  logic [15:0] m_out;

  always @(posedge clk) begin
    bit nd, ne;
    nd = 1'b0;
    ne = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_bank[0][i] = 16'(i + 1);
        m_bank[1][i] = '0;
      end
      m_active = 1'b0; m_loading = 1'b0; m_cnt = 0;
      m_done = 1'b0; m_err = 1'b0; m_out = '0; m_valid = 1'b1;
    end else begin
      m_out = (addr < 16) ? m_bank[m_active][addr[3:0]] : 16'h0;
      if (m_done) m_active = !m_active;
      if (m_loading) begin
        if (load_abort) begin
          m_loading = 1'b0;
        end else if (coef_valid) begin
          m_bank[!m_active][m_cnt] = coef_data;
          m_cnt++;
          if (coef_last || m_cnt == 16) begin
            m_loading = 1'b0;
            if (coef_last && m_cnt == 16) nd = 1'b1;
            else ne = 1'b1;
          end
        end
      end else if (!m_done && !m_err && load_start) begin
        m_loading = 1'b1;
        m_cnt = 0;
      end
      m_done = nd;
      m_err  = ne;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("coefficient_out", 32'(coefficient_out), 32'(m_out));
      chk("active_bank", 32'(active_bank), 32'(m_active));
      chk("coef_ready", 32'(coef_ready), 32'(m_loading));
      chk("load_busy", 32'(load_busy), 32'(m_loading));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("load_err", 32'(load_err), 32'(m_err));
      if (load_done === 1'b1) done_cnt++;
      if (load_err === 1'b1) err_cnt++;
    end
  end

  task automatic tick();
    if (rand_addr) addr = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 17));
    @(posedge clk);
    #1;
  endtask

  // base<0 selects random data; last_at=16 means coef_last never set.
  task automatic do_load(input int base, input int last_at, input int abort_at,
                         input int rst_at, input bit gaps);
    bit v;
    int tries;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == abort_at) begin
        load_abort = 1'b1; coef_valid = 1'b1; coef_data = 16'hDEAD;
        tick();
        load_abort = 1'b0; coef_valid = 1'b0;
        break;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        break;
      end
      tries = 0;
      do begin
        v = (gaps && tries < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
        coef_valid = v;
        coef_data  = (base < 0) ? 16'($urandom) : 16'(base + k);
        coef_last  = (k == last_at);
        load_start = ($urandom_range(0, 7) == 0);
        tick();
        tries++;
      end while (!v);
      if (k == last_at) break;
    end
    coef_valid = 1'b0; coef_last = 1'b0; load_start = 1'b0;
    tick();
  endtask

  task automatic sweep(input int base, input string name);
    rand_addr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 16'(i);
      tick();
      chk(name, 32'(coefficient_out), 32'(base + i));
    end
    addr = 16'd16;
    tick();
    chk("lit_addr16", 32'(coefficient_out), 32'd0);
    addr = 16'hFFFF;
    tick();
    chk("lit_addrFFFF", 32'(coefficient_out), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int d0, e0;
    tick();
    tick();
    rst = 1'b0;
    chk("lit_reset_active", 32'(active_bank), 32'd0);
    chk("lit_reset_ready", 32'(coef_ready), 32'd0);
    sweep(1, "lit_ramp");

    // Clean load with reads during the load.
    d0 = done_cnt;
    rand_addr = 1'b1;
    do_load(100, 15, -1, -1, 1'b0);
    chk("lit_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("lit_active_after_load", 32'(active_bank), 32'd1);
    sweep(100, "lit_bank100");

    // Same data with valid gaps, into the other bank.
    rand_addr = 1'b1;
    do_load(100, 15, -1, -1, 1'b1);
    chk("lit_active_after_gaps", 32'(active_bank), 32'd0);
    sweep(100, "lit_gap_bank100");

    // Too short, then too long, from a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    do_load(50, 4, -1, -1, 1'b0);
    do_load(60, 16, -1, -1, 1'b0);
    chk("lit_err_pulses", 32'(err_cnt - e0), 32'd2);
    chk("lit_no_done_on_err", 32'(done_cnt - d0), 32'd0);
    chk("lit_active_after_err", 32'(active_bank), 32'd0);
    sweep(1, "lit_ramp_after_err");

    // Abort after 8 beats, then a full load back-to-back.
    d0 = done_cnt; e0 = err_cnt;
    do_load(70, 15, 8, -1, 1'b0);
    chk("lit_abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("lit_abort_no_err", 32'(err_cnt - e0), 32'd0);
    do_load(200, 15, -1, -1, 1'b0);
    do_load(300, 15, -1, -1, 1'b0);
    chk("lit_b2b_done", 32'(done_cnt - d0), 32'd2);
    sweep(300, "lit_bank300");

    // Reset in the middle of a load.
    do_load(400, 15, -1, 10, 1'b0);
    chk("lit_midrst_active", 32'(active_bank), 32'd0);
    sweep(1, "lit_ramp_after_rst");

    // Randomized mix of all load outcomes.
    rand_addr = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: do_load(-1, 15, -1, -1, 1'b0);
        1: do_load(-1, $urandom_range(0, 14), -1, -1, 1'b1);
        2: do_load(-1, 16, -1, -1, 1'b1);
        3: do_load(-1, 15, $urandom_range(0, 15), -1, 1'b1);
        4: do_load(-1, 15, -1, $urandom_range(0, 15), 1'b0);
        default: do_load(-1, 15, -1, -1, 1'b1);
      endcase
      repeat ($urandom_range(0, 2)) begin
        load_abort = 1'($urandom_range(0, 1));
        tick();
      end
      load_abort = 1'b0;
    end
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
